// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key schedule:
//   - legal round counts and helpers that derive the key-word count (Nk)
//     and the total expanded word count (NW) from the round count
//   - FSM state encoding used by key_expansion
//   - the forward S-box table plus SubWord / RotWord / xtime helpers
// No ports; imported by aes_subword and key_expansion.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int ROUNDS_AES128 = 10;
    localparam int ROUNDS_AES192 = 12;
    localparam int ROUNDS_AES256 = 14;

    localparam int DEFAULT_MAX_ROUND = ROUNDS_AES128;

    // Nk and NW for the default (AES-128) configuration.
    localparam int NK_DEFAULT = DEFAULT_MAX_ROUND - 6;
    localparam int NW_DEFAULT = 4 * (DEFAULT_MAX_ROUND + 1);

    // The window holding w[i-Nk..i-1] is sized for the largest key (AES-256).
    localparam int WINDOW_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } expandState_t;

    // Only 10, 12 and 14 rounds describe a real AES variant.
    function automatic bit isLegalRound(input int rounds);
        return (rounds == ROUNDS_AES128) ||
               (rounds == ROUNDS_AES192) ||
               (rounds == ROUNDS_AES256);
    endfunction

    // Number of 32-bit words in the cipher key (Nk).
    function automatic int keyWords(input int rounds);
        return rounds - 6;
    endfunction

    // Number of 32-bit words in the whole expanded schedule (NW).
    function automatic int totalWords(input int rounds);
        return 4 * (rounds + 1);
    endfunction

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Single-byte S-box lookup.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[8 * (255 - int'(b)) +: 8];
    endfunction

    // Apply the S-box to every byte of a word.
    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Cyclic left rotation by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// ---------------------------------------------------------------------------
// aes_subword
// Purely combinational SubWord: four parallel S-box lookups on one word.
// Ports:
//   src     input  32  word to substitute
//   subbed  output 32  byte-wise S-box image of src
// ---------------------------------------------------------------------------
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] src,
    output logic [31:0] subbed
);

    // Each byte goes through its own S-box lookup; no state, no clock.
    always_comb begin
        subbed = {sbox(src[31:24]), sbox(src[23:16]), sbox(src[15:8]), sbox(src[7:0])};
    end

endmodule

// File: rtl/key_expansion.sv
// ---------------------------------------------------------------------------
// key_expansion
// Iterative AES key schedule producing one 32-bit round-key word per clock.
// Supports AES-128/192/256 through maxRound (10, 12 or 14 only).
// Ports:
//   clk        input   1                  rising-edge clock
//   reset_n    input   1                  synchronous active-low reset
//   start      input   1                  begin expansion (honoured in IDLE/DONE)
//   key_in     input   256                cipher key, left-justified
//   busy       output  1                  expansion in progress
//   done       output  1                  one-cycle pulse on the last word
//   key_valid  output  1                  full_key complete and stable
//   full_key   output  128*(maxRound+1)   round keys, round 0 at the LSBs;
//                                         word w[i] sits at bits
//                                         [32*(i^3) +: 32]
// ---------------------------------------------------------------------------
module key_expansion
    import aes_pkg::*;
#(
    parameter int maxRound = DEFAULT_MAX_ROUND
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [255:0]                  key_in,
    output logic                          busy,
    output logic                          done,
    output logic                          key_valid,
    output logic [128*(maxRound+1)-1:0]   full_key
);

    localparam int NK    = keyWords(maxRound);
    localparam int NW    = totalWords(maxRound);
    localparam int IDX_W = 6;

    expandState_t     state;
    logic [IDX_W-1:0] idx;
    logic [2:0]       wrap;
    logic [7:0]       rcon;
    logic [31:0]      win [WINDOW_WORDS];

    logic [31:0]      prevWord;
    logic [31:0]      oldestWord;
    logic [31:0]      subIn;
    logic [31:0]      subOut;
    logic [31:0]      temp;
    logic [31:0]      nextWord;

    // A single SubWord unit serves both the RotWord/rcon step at the start
    // of each Nk-word group and the extra AES-256 substitution mid-group,
    // since the two never happen on the same word.
    aes_subword subwordUnit (
        .src    (subIn),
        .subbed (subOut)
    );

    // Next-word datapath. The window keeps w[i-Nk] at slot 0 and w[i-1] at
    // slot Nk-1, so both operands are fixed slots. The wrap counter stands
    // in for i mod Nk so there is no divider anywhere.
    always_comb begin
        prevWord   = win[NK-1];
        oldestWord = win[0];
        subIn      = (wrap == 3'd0) ? rotWord(prevWord) : prevWord;
        temp       = prevWord;
        if (wrap == 3'd0) begin
            temp = subOut ^ {rcon, 24'h000000};
        end else if ((NK == 8) && (wrap == 3'd4)) begin
            temp = subOut;
        end
        nextWord = oldestWord ^ temp;
    end

    // Control FSM together with the window, rcon and full_key registers.
    // Loading copies the cipher key into the low Nk words of full_key and
    // primes the window; all eight window slots are loaded so every key_in
    // bit has a defined destination even when Nk < 8. Higher full_key words
    // from an earlier run are left alone until EXPAND overwrites them.
    // During EXPAND exactly one 32-bit slice of full_key changes per edge.
    // start is deliberately not looked at in EXPAND, so a stray pulse can
    // neither restart nor stretch an expansion already underway.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            wrap      <= '0;
            rcon      <= 8'h01;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_valid <= 1'b0;
            full_key  <= '0;
            for (int k = 0; k < WINDOW_WORDS; k++) begin
                win[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int k = 0; k < WINDOW_WORDS; k++) begin
                            win[k] <= key_in[255-32*k -: 32];
                        end
                        for (int k = 0; k < NK; k++) begin
                            full_key[32*(k^3) +: 32] <= key_in[255-32*k -: 32];
                        end
                        idx       <= IDX_W'(NK);
                        wrap      <= 3'd0;
                        rcon      <= 8'h01;
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int w = NK; w < NW; w++) begin
                        if (idx == IDX_W'(w)) begin
                            full_key[32*(w^3) +: 32] <= nextWord;
                        end
                    end
                    for (int k = 0; k < WINDOW_WORDS - 1; k++) begin
                        if (k < NK - 1) begin
                            win[k] <= win[k+1];
                        end
                    end
                    win[NK-1] <= nextWord;
                    idx       <= idx + IDX_W'(1);
                    wrap      <= (wrap == 3'(NK - 1)) ? 3'd0 : wrap + 3'd1;
                    if (wrap == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    if (idx == IDX_W'(NW - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
